// File: rtl/ps2_pkg.sv
// Shared types, frame constants and helpers for the PS/2 host controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_INHIBIT = 3'd2,
    ST_TX_BITS = 3'd3,
    ST_TX_ACK  = 3'd4
  } ps2_state_e;

  localparam int RX_BITS = 11;
  localparam int TX_BITS = 10;

  function automatic int us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 32'sd1_000_000) * us;
  endfunction

  // Odd parity: the returned bit makes the total number of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Receive-side check over data plus parity; 1 means the parity is wrong.
  function automatic logic parity_bad(input logic [8:0] par_and_data);
    return ~(^par_and_data);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// RX FIFO holding {parity-bad, byte} entries; simultaneous push and pop are
// both honoured, including when full.
module ps2_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [8:0] din,
  input  logic       pop,
  output logic [8:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;

  logic          w_do_push;
  logic          w_do_pop;
  logic [AW:0]   w_count_nxt;

  // Qualify push/pop against the current fill state and compute next count.
  always_comb begin
    w_do_pop  = pop & ~r_empty;
    w_do_push = push & (~r_full | w_do_pop);
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 9'd0;
      end
      r_wr    <= {AW{1'b0}};
      r_rd    <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == {(AW+1){1'b0}});
      r_full  <= (w_count_nxt == CNT_FULL);
    end
  end

  assign dout  = r_mem[r_rd];
  assign empty = r_empty;
  assign full  = r_full;

endmodule

// File: rtl/ps2_host_fifo.sv
// PS/2 host: receives device frames into an RX FIFO, transmits host-to-device
// bytes after a clock inhibit, checks ACK, and guards frames with a watchdog.
module ps2_host_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 2000,
  parameter int RX_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_d,
  input  logic       ps2_data_d,
  output logic       ps2_clk_q,
  output logic       ps2_data_q,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_valid,
  input  logic       rx_pop,
  output logic       rx_frame_err,
  output logic       rx_overflow
);

  localparam int INH_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int TO_CYC  = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INH_CYC);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TO_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [3:0]       RX_LAST  = 4'(RX_BITS - 1);
  localparam logic [3:0]       TX_LAST  = 4'(TX_BITS - 1);

  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_dat_s1, r_dat_s2;

  ps2_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_rx_sh;
  logic [9:0]       r_tx_sh;
  logic [7:0]       r_tx_byte;
  logic             r_clk_q, r_data_q;
  logic             r_tx_ready, r_tx_done, r_tx_err;
  logic             r_frame_err, r_overflow;

  logic             w_fe;
  logic [10:0]      w_frame;
  logic             w_rx_last;
  logic             w_frame_ok;
  logic             w_perr;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [8:0]       w_dout;
  logic             w_empty;
  logic             w_full;

  // Two-stage synchronisers plus the previous-clock register for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b0;
      r_clk_s2   <= 1'b0;
      r_clk_prev <= 1'b0;
      r_dat_s1   <= 1'b0;
      r_dat_s2   <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk_d;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data_d;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fe = r_clk_prev & ~r_clk_s2;

  // Frame decode on the 11th edge: [0]=start, [8:1]=byte, [9]=parity, [10]=stop.
  always_comb begin
    w_frame    = {r_dat_s2, r_rx_sh};
    w_rx_last  = (r_state == ST_RX) && w_fe && (r_bit_cnt == RX_LAST);
    w_frame_ok = (w_frame[0] == 1'b0) && (w_frame[10] == 1'b1);
    w_perr     = parity_bad(w_frame[9:1]);
    w_pop      = rx_pop & ~w_empty;
    w_push     = w_rx_last & w_frame_ok & (~w_full | w_pop);
    w_drop     = w_rx_last & w_frame_ok & w_full & ~w_pop;
  end

  // Main controller; one counter serves as inhibit timer and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_bit_cnt   <= 4'd0;
      r_rx_sh     <= 10'd0;
      r_tx_sh     <= 10'd0;
      r_tx_byte   <= 8'd0;
      r_clk_q     <= 1'b0;
      r_data_q    <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_tx_done   <= 1'b0;
      r_tx_err    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_tx_done   <= 1'b0;
      r_tx_err    <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_tx_ready <= 1'b1;
          r_clk_q    <= 1'b0;
          r_data_q   <= 1'b0;
          if (tx_valid && r_tx_ready) begin
            r_tx_byte  <= tx_data;
            r_cnt      <= INH_LOAD;
            r_clk_q    <= 1'b1;
            r_tx_ready <= 1'b0;
            r_state    <= ST_INHIBIT;
          end else if (w_fe) begin
            r_rx_sh    <= {r_dat_s2, r_rx_sh[9:1]};
            r_bit_cnt  <= 4'd1;
            r_cnt      <= TO_LOAD;
            r_tx_ready <= 1'b0;
            r_state    <= ST_RX;
          end
        end
        ST_RX: begin
          if (w_fe) begin
            r_cnt <= TO_LOAD;
            if (r_bit_cnt == RX_LAST) begin
              r_frame_err <= ~w_frame_ok;
              r_state     <= ST_IDLE;
            end else begin
              r_rx_sh   <= {r_dat_s2, r_rx_sh[9:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (r_cnt == CNT_ZERO) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        // Releasing at count 1 keeps the clock low for exactly INH_CYC cycles.
        ST_INHIBIT: begin
          if (r_cnt == CNT_ONE) begin
            r_clk_q   <= 1'b0;
            r_data_q  <= 1'b1;
            r_tx_sh   <= {1'b1, odd_parity(r_tx_byte), r_tx_byte};
            r_bit_cnt <= 4'd0;
            r_cnt     <= TO_LOAD;
            r_state   <= ST_TX_BITS;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_TX_BITS: begin
          if (w_fe) begin
            r_data_q <= ~r_tx_sh[0];
            r_tx_sh  <= {1'b0, r_tx_sh[9:1]};
            r_cnt    <= TO_LOAD;
            if (r_bit_cnt == TX_LAST) begin
              r_state <= ST_TX_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (r_cnt == CNT_ZERO) begin
            r_tx_err <= 1'b1;
            r_clk_q  <= 1'b0;
            r_data_q <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_TX_ACK: begin
          if (w_fe) begin
            r_tx_done <= ~r_dat_s2;
            r_tx_err  <= r_dat_s2;
            r_data_q  <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (r_cnt == CNT_ZERO) begin
            r_tx_err <= 1'b1;
            r_clk_q  <= 1'b0;
            r_data_q <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_clk_q  <= 1'b0;
          r_data_q <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  ps2_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({w_perr, w_frame[8:1]}),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );

  assign ps2_clk_q    = r_clk_q;
  assign ps2_data_q   = r_data_q;
  assign tx_ready     = r_tx_ready;
  assign tx_done      = r_tx_done;
  assign tx_err       = r_tx_err;
  assign rx_data      = w_dout[7:0];
  assign rx_perr      = w_dout[8];
  assign rx_valid     = ~w_empty;
  assign rx_frame_err = r_frame_err;
  assign rx_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_host_fifo.sv
// Scoreboard bench: a PS/2 device model drives the open-drain bus, expected
// RX entries / TX outcomes are queued and a monitor compares DUT outputs.
module tb_ps2_host_fifo;

  localparam int CLK_HZ     = 1_000_000;
  localparam int INHIBIT_US = 20;
  localparam int TIMEOUT_US = 300;
  localparam int RX_DEPTH   = 4;
  localparam int INH_CYC    = (CLK_HZ / 1_000_000) * INHIBIT_US;
  localparam int TO_CYC     = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int HALF       = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       dev_clk, dev_data;
  logic       ps2_clk_d, ps2_data_d, ps2_clk_q, ps2_data_q;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_done, tx_err;
  logic [7:0] rx_data;
  logic       rx_perr, rx_valid, rx_pop, rx_frame_err, rx_overflow;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] exp_rx[$];
  logic       exp_tx[$];
  int         exp_ferr = 0;
  int         seen_ferr = 0;
  bit         pop_en = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;

  ps2_host_fifo #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US), .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_d(ps2_clk_d), .ps2_data_d(ps2_data_d),
    .ps2_clk_q(ps2_clk_q), .ps2_data_q(ps2_data_q),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow)
  );

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_d  = dev_clk & ~ps2_clk_q;
  assign ps2_data_d = dev_data & ~ps2_data_q;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random popping; the value is stable from posedge+1 to the next posedge.
  initial begin
    rx_pop = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rx_pop = pop_en && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: compares every popped entry and every TX outcome pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (rx_valid && rx_pop) begin
        if (exp_rx.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rx_unexpected_entry: got 0x%0h, expected no entry", {rx_perr, rx_data});
        end else begin
          check("rx_entry", {rx_perr, rx_data}, exp_rx.pop_front());
        end
      end
      if (tx_done || tx_err) begin
        check("tx_done_err_exclusive", tx_done & tx_err, 0);
        if (exp_tx.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_unexpected_pulse: got done=%0b err=%0b, expected none", tx_done, tx_err);
        end else begin
          check("tx_outcome_done", tx_done, exp_tx.pop_front());
        end
      end
      if (prev_done) check("tx_done_width", tx_done, 0);
      if (prev_err)  check("tx_err_width", tx_err, 0);
      if (rx_frame_err) seen_ferr++;
      prev_done = tx_done;
      prev_err  = tx_err;
    end
  end

  task automatic dev_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      dev_data = bits[i];
      cyc(HALF);
      dev_clk = 1'b0;
      cyc(HALF);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  // Device-to-host frame; the model decides what the host must store.
  task automatic dev_frame(input logic [7:0] b, input bit bad_par, input bit bad_start, input bit bad_stop);
    logic        p;
    logic [10:0] fr;
    p  = (~(^b)) ^ bad_par;
    fr = {~bad_stop, p, b, bad_start};
    if (bad_start || bad_stop) exp_ferr++;
    else if (exp_rx.size() < RX_DEPTH) exp_rx.push_back({bad_par, b});
    dev_bits(fr, 11);
    cyc(2 * HALF);
  endtask

  task automatic wait_ready(input int budget);
    int t;
    t = 0;
    while (!tx_ready && t < budget) begin
      cyc(1);
      t++;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_rx.size() != 0 && t < 5000) begin
      cyc(1);
      t++;
    end
    check("rx_drained_entries_left", exp_rx.size(), 0);
  endtask

  // Host-to-device byte; mode 0 = device ACKs, 1 = no ACK, 2 = device silent.
  task automatic host_tx(input logic [7:0] b, input int mode);
    int         inh;
    logic [9:0] got;
    wait_ready(2000);
    check("tx_ready_before_send", tx_ready, 1);
    exp_tx.push_back(mode == 0);
    tx_data  = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("tx_ready_low_after_accept", tx_ready, 0);
    inh = 0;
    while (ps2_clk_q && inh < 10 * INH_CYC) begin
      inh++;
      cyc(1);
    end
    check("inhibit_cycles", inh, INH_CYC);
    check("start_bit_drive", ps2_data_q, 1);
    if (mode != 2) begin
      for (int k = 0; k < 10; k++) begin
        cyc(HALF);
        dev_clk = 1'b0;
        cyc(HALF);
        got[k] = ps2_data_d;
        dev_clk = 1'b1;
      end
      check("tx_bits_on_bus", got, {1'b1, ~(^b), b});
      dev_data = (mode == 0) ? 1'b0 : 1'b1;
      cyc(HALF);
      dev_clk = 1'b0;
      cyc(HALF);
      dev_clk = 1'b1;
      dev_data = 1'b1;
    end
    wait_ready(TO_CYC + 200);
    check("tx_ready_after_tx", tx_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; dev_clk = 1'b1; dev_data = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    cyc(3);
    check("rst_clk_q", ps2_clk_q, 0);
    check("rst_data_q", ps2_data_q, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", {rx_perr, rx_data}, 0);
    check("rst_pulses", {tx_done, tx_err, rx_frame_err, rx_overflow}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("tx_ready_still_low", tx_ready, 0);
    cyc(1);
    check("tx_ready_after_reset", tx_ready, 1);
    pop_en = 1'b1;

    // Directed RX: good 0x1C, then 0x1C with a wrong parity bit.
    dev_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    dev_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    wait_drain();
    cyc(2);
    check("rx_valid_after_pops", rx_valid, 0);

    // Directed TX: ACK, no ACK, silent device (watchdog).
    host_tx(8'hFF, 0);
    host_tx(8'hFF, 1);
    host_tx(8'h5A, 2);

    // Overflow: one more good frame than the FIFO holds, no pops.
    pop_en = 1'b0;
    cyc(4);
    for (int i = 0; i <= RX_DEPTH; i++) dev_frame(8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    check("overflow_set", rx_overflow, 1);
    check("overflow_rx_valid", rx_valid, 1);
    pop_en = 1'b1;
    wait_drain();
    check("overflow_sticky", rx_overflow, 1);

    // Reset in the middle of a frame: lines released, state cleared.
    dev_bits(11'h5F2, 5);
    rst = 1'b1;
    cyc(1);
    check("midrst_lines", {ps2_clk_q, ps2_data_q}, 0);
    check("midrst_flags", {rx_valid, rx_overflow, tx_ready}, 0);
    rst = 1'b0;
    cyc(4);

    // Watchdog on a stalled RX frame, then a clean 0xAA.
    dev_bits(11'h6A4, 5);
    exp_ferr++;
    cyc(TO_CYC - 30);
    check("rx_timeout_not_early", seen_ferr, exp_ferr - 1);
    cyc(60);
    check("rx_timeout_fired", seen_ferr, exp_ferr);
    dev_frame(8'hAA, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Randomised mix of RX frames (good, bad parity, bad framing) and TX.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) dev_frame(8'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      else if (op == 6) begin
        if ($urandom_range(0, 1) == 1) dev_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
        else dev_frame(8'($urandom), 1'b0, 1'b0, 1'b1);
      end else host_tx(8'($urandom), $urandom_range(0, 1));
      cyc($urandom_range(0, 20));
    end
    wait_drain();
    cyc(20);
    check("tx_outcomes_outstanding", exp_tx.size(), 0);
    check("frame_err_count", seen_ferr, exp_ferr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
